edge_pipe_nch: RTL and testbench

EDGE_PIPE_NCH -- requirements
Module: edge_pipe_nch

---
 rtl/edge_pipe_nch.sv | 268 ++++++++++++++++++++++++++
 tb/tb_edge_pipe_nch.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/edge_pipe_nch.sv
// edge_pipe_nch: multi-channel 3x3 Sobel edge pipeline fed by two line buffers.
// Four register stages: window shift, Gx/Gy, saturated magnitude, channel max + mode mux.
// Optional feature macro: EDGE_PIPE_CARTOON_EN (mode 11 black-outline cartoon output);
// when undefined, mode 11 behaves exactly like mode 01.
module edge_pipe_nch #(
  parameter int CH   = 3,
  parameter int DW   = 8,
  parameter int MAXW = 2048,
  parameter int PW   = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sof,
  input  logic             valid_in,
  input  logic [12:0]      col,
  input  logic [12:0]      line_len,
  input  logic [1:0]       mode,
  input  logic [DW-1:0]    thresh,
  input  logic [CH*DW-1:0] pixel_in,
  input  logic [PW-1:0]    pass_in,
  output logic             valid_out,
  output logic [CH*DW-1:0] pixel_out,
  output logic [DW-1:0]    edge_out,
  output logic [PW-1:0]    pass_thru
);

  localparam int AW  = $clog2(MAXW);
  localparam int PXW = CH * DW;
  localparam int GW  = DW + 3;

  typedef enum logic [1:0] {
    MODE_BYPASS  = 2'b00,
    MODE_MAG     = 2'b01,
    MODE_THR     = 2'b10,
    MODE_CARTOON = 2'b11
  } mode_e;

  // lb0 holds the previous row (pixel + sideband); lb1 holds the row before it.
  // The sideband of row-2 never reaches the output, so lb1 keeps only pixel data.
  logic [PXW+PW-1:0] lb0_q [MAXW];
  logic [PXW-1:0]    lb1_q [MAXW];

  logic [AW-1:0]     addr;
  logic [PXW+PW-1:0] rd0;
  logic [PXW-1:0]    rd1;
  logic              lastCol;
  logic [1:0]        rowEff;
  logic              maskIn;
  mode_e             modeEff;
  logic [1:0]        rowCnt_q, rowCnt_d;

  // S1: window[row][column], row 0 = two rows up, column 0 = newest (rightmost)
  logic [PXW-1:0] win_q [3][3];
  logic [PW-1:0]  pass0_q, pass1_q;
  logic           mask1_q, v1_q;
  mode_e          mode1_q;
  logic [DW-1:0]  thr1_q;

  // S2: signed gradients per channel
  logic [GW-1:0]  gx_d [CH];
  logic [GW-1:0]  gy_d [CH];
  logic [GW-1:0]  gx_q [CH];
  logic [GW-1:0]  gy_q [CH];
  logic [PXW-1:0] cen2_q;
  logic [PW-1:0]  pass2_q;
  logic           mask2_q, v2_q;
  mode_e          mode2_q;
  logic [DW-1:0]  thr2_q;

  // S3: saturated magnitudes per channel
  logic [DW-1:0]  mag_d  [CH];
  logic [DW-1:0]  mag3_q [CH];
  logic [PXW-1:0] cen3_q;
  logic [PW-1:0]  pass3_q;
  logic           v3_q;
  mode_e          mode3_q;
  logic [DW-1:0]  thr3_q;

  // S4 combinational results
  logic [DW-1:0]  edge_d;
  logic [PXW-1:0] pix_d;

  function automatic logic [GW-1:0] ext(input logic [DW-1:0] v);
    ext = {3'b000, v};
  endfunction

  function automatic logic [GW-1:0] colSum(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                            input logic [DW-1:0] c);
    colSum = ext(a) + (ext(b) << 1) + ext(c);
  endfunction

  function automatic logic [DW-1:0] satMag(input logic [GW-1:0] gx, input logic [GW-1:0] gy);
    logic [GW-1:0] ax, ay, s;
    ax = gx[GW-1] ? (~gx + GW'(1)) : gx;
    ay = gy[GW-1] ? (~gy + GW'(1)) : gy;
    s  = ax + ay;
    satMag = (|s[GW-1:DW]) ? {DW{1'b1}} : s[DW-1:0];
  endfunction

  assign addr    = col[AW-1:0];
  assign rd0     = lb0_q[addr];
  assign rd1     = lb1_q[addr];
  assign lastCol = (col == line_len - 13'd1);
  assign rowEff  = sof ? 2'd0 : rowCnt_q;
  // The centre of column 0 is the previous row's last column, the centre of column 1 is column 0:
  // both are borders, as is any window that does not yet span three real rows.
  assign maskIn  = (rowEff != 2'd2) || (col == 13'd0) || (col == 13'd1);
  assign modeEff = en ? mode_e'(mode) : MODE_BYPASS;

  // Line buffers shift a column down one row on every valid pixel; contents survive reset
  always_ff @(posedge clk) begin
    if (valid_in) begin
      lb0_q[addr] <= {pass_in, pixel_in};
      lb1_q[addr] <= rd0[PXW-1:0];
    end
  end

  // Row counter next state: clear on sof, count completed lines, saturate at 2
  always_comb begin
    rowCnt_d = rowCnt_q;
    if (valid_in) begin
      if (sof) begin
        rowCnt_d = 2'd0;
      end else if (lastCol && rowCnt_q != 2'd2) begin
        rowCnt_d = rowCnt_q + 2'd1;
      end
    end
  end

  // Row counter register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rowCnt_q <= 2'd0;
    else      rowCnt_q <= rowCnt_d;
  end

  // S1: shift the 3x3 window and latch per-pixel controls only when a pixel arrives
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++) win_q[r][c] <= '0;
      pass0_q <= '0;
      pass1_q <= '0;
      mask1_q <= 1'b0;
      mode1_q <= MODE_BYPASS;
      thr1_q  <= '0;
      v1_q    <= 1'b0;
    end else begin
      v1_q <= valid_in;
      if (valid_in) begin
        for (int r = 0; r < 3; r++) begin
          win_q[r][2] <= win_q[r][1];
          win_q[r][1] <= win_q[r][0];
        end
        win_q[0][0] <= rd1;
        win_q[1][0] <= rd0[PXW-1:0];
        win_q[2][0] <= pixel_in;
        pass0_q     <= rd0[PXW+PW-1:PXW];
        pass1_q     <= pass0_q;
        mask1_q     <= maskIn;
        mode1_q     <= modeEff;
        thr1_q      <= thresh;
      end
    end
  end

  // S2 combinational: Sobel Gx (right minus left) and Gy (bottom minus top) per channel
  always_comb begin
    for (int ch = 0; ch < CH; ch++) begin
      gx_d[ch] = colSum(win_q[0][0][ch*DW +: DW], win_q[1][0][ch*DW +: DW], win_q[2][0][ch*DW +: DW])
               - colSum(win_q[0][2][ch*DW +: DW], win_q[1][2][ch*DW +: DW], win_q[2][2][ch*DW +: DW]);
      gy_d[ch] = colSum(win_q[2][0][ch*DW +: DW], win_q[2][1][ch*DW +: DW], win_q[2][2][ch*DW +: DW])
               - colSum(win_q[0][0][ch*DW +: DW], win_q[0][1][ch*DW +: DW], win_q[0][2][ch*DW +: DW]);
    end
  end

  // S2 register: gradients plus the centre pixel and its sideband
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int ch = 0; ch < CH; ch++) begin
        gx_q[ch] <= '0;
        gy_q[ch] <= '0;
      end
      cen2_q  <= '0;
      pass2_q <= '0;
      mask2_q <= 1'b0;
      mode2_q <= MODE_BYPASS;
      thr2_q  <= '0;
      v2_q    <= 1'b0;
    end else begin
      for (int ch = 0; ch < CH; ch++) begin
        gx_q[ch] <= gx_d[ch];
        gy_q[ch] <= gy_d[ch];
      end
      cen2_q  <= win_q[1][1];
      pass2_q <= pass1_q;
      mask2_q <= mask1_q;
      mode2_q <= mode1_q;
      thr2_q  <= thr1_q;
      v2_q    <= v1_q;
    end
  end

  // S3 combinational: |Gx|+|Gy| saturated, forced to zero on border/unfilled windows
  always_comb begin
    for (int ch = 0; ch < CH; ch++) begin
      mag_d[ch] = mask2_q ? '0 : satMag(gx_q[ch], gy_q[ch]);
    end
  end

  // S3 register: magnitudes and carried controls
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int ch = 0; ch < CH; ch++) mag3_q[ch] <= '0;
      cen3_q  <= '0;
      pass3_q <= '0;
      mode3_q <= MODE_BYPASS;
      thr3_q  <= '0;
      v3_q    <= 1'b0;
    end else begin
      for (int ch = 0; ch < CH; ch++) mag3_q[ch] <= mag_d[ch];
      cen3_q  <= cen2_q;
      pass3_q <= pass2_q;
      mode3_q <= mode2_q;
      thr3_q  <= thr2_q;
      v3_q    <= v2_q;
    end
  end

  // S4 combinational: strongest channel becomes edge_out, then select the output pixel by mode
  always_comb begin
    edge_d = '0;
    pix_d  = cen3_q;
    for (int ch = 0; ch < CH; ch++) begin
      if (mag3_q[ch] > edge_d) edge_d = mag3_q[ch];
    end
    case (mode3_q)
      MODE_BYPASS: pix_d = cen3_q;
      MODE_MAG: begin
        for (int ch = 0; ch < CH; ch++) pix_d[ch*DW +: DW] = mag3_q[ch];
      end
      MODE_THR: pix_d = (edge_d >= thr3_q) ? {PXW{1'b1}} : '0;
      MODE_CARTOON: begin
`ifdef EDGE_PIPE_CARTOON_EN
        pix_d = (edge_d < thr3_q) ? cen3_q : '0;
`else
        for (int ch = 0; ch < CH; ch++) pix_d[ch*DW +: DW] = mag3_q[ch];
`endif
      end
    endcase
  end

  // S4 register: drive the outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_out <= 1'b0;
      pixel_out <= '0;
      edge_out  <= '0;
      pass_thru <= '0;
    end else begin
      valid_out <= v3_q;
      pixel_out <= pix_d;
      edge_out  <= edge_d;
      pass_thru <= pass3_q;
    end
  end

endmodule

// File: tb/tb_edge_pipe_nch.sv
// Directed testbench for edge_pipe_nch: frames of known images, outputs collected in order
// and compared against hand-derived expectations. Handles EDGE_PIPE_CARTOON_EN either way.
module tb_edge_pipe_nch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en, sof, valid_in;
  logic [12:0] col, line_len;
  logic [1:0]  mode;
  logic [7:0]  thresh;
  logic [23:0] pixel_in, pass_in;
  logic        valid_out;
  logic [23:0] pixel_out;
  logic [7:0]  edge_out;
  logic [23:0] pass_thru;

  int total = 0;
  int bad   = 0;

  logic [23:0] qPix[$];
  logic [7:0]  qEdge[$];
  logic [23:0] qPass[$];

  edge_pipe_nch #(.CH(3), .DW(8), .MAXW(2048), .PW(24)) dut (
    .clk(clk), .rst(rst), .en(en), .sof(sof), .valid_in(valid_in), .col(col),
    .line_len(line_len), .mode(mode), .thresh(thresh), .pixel_in(pixel_in),
    .pass_in(pass_in), .valid_out(valid_out), .pixel_out(pixel_out),
    .edge_out(edge_out), .pass_thru(pass_thru)
  );

  always #5 clk = ~clk;

  // Collect every valid output in arrival order, sampled away from the rising edge
  always @(negedge clk) begin
    if (valid_out) begin
      qPix.push_back(pixel_out);
      qEdge.push_back(edge_out);
      qPass.push_back(pass_thru);
    end
  end

  function automatic logic [23:0] splat(input logic [7:0] v);
    return {v, v, v};
  endfunction

  // 0 flat 100, 1 vertical step at col 4, 2 distinctive ramp, 3 horizontal step at row 2
  function automatic logic [23:0] pixAt(input int pat, input int r, input int c);
    case (pat)
      0: return splat(8'd100);
      1: return (c >= 4) ? splat(8'd200) : 24'h0;
      2: return {8'(r + 1), 8'(c + 1), 8'(r * 8 + c)};
      default: return (r >= 2) ? {8'd200, 8'd0, 8'd20} : 24'h0;
    endcase
  endfunction

  function automatic logic [23:0] passAt(input int r, input int c);
    return 24'(r * 256 + c);
  endfunction

  task automatic applyStimulus(input int r, input int c, input int pat, input logic s);
    @(negedge clk);
    valid_in = 1'b1;
    sof      = s;
    col      = 13'(c);
    pixel_in = pixAt(pat, r, c);
    pass_in  = passAt(r, c);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    valid_in = 1'b0;
    sof      = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic clearQueues();
    qPix.delete();
    qEdge.delete();
    qPass.delete();
  endtask

  task automatic runFrame(input int rows, input int len, input int pat, input logic withSof);
    clearQueues();
    line_len = 13'(len);
    for (int r = 0; r < rows; r++)
      for (int c = 0; c < len; c++)
        applyStimulus(r, c, pat, withSof && r == 0 && c == 0);
    idle(6);
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (valid_out !== 1'b0)  begin bad++; $display("[TB] FAIL reset_valid got=%0d want=0", valid_out); end
    total++; if (pixel_out !== 24'h0) begin bad++; $display("[TB] FAIL reset_pixel got=%h want=000000", pixel_out); end
    total++; if (edge_out !== 8'h0)   begin bad++; $display("[TB] FAIL reset_edge got=%0d want=0", edge_out); end
    total++; if (pass_thru !== 24'h0) begin bad++; $display("[TB] FAIL reset_pass got=%h want=000000", pass_thru); end
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_flat();
    mode = 2'b01; en = 1'b1; thresh = 8'd0;
    runFrame(4, 8, 0, 1'b1);
    total++;
    if (qEdge.size() !== 32) begin
      bad++; $display("[TB] FAIL flat_count got=%0d want=32", qEdge.size());
    end else begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 8; c++) begin
          total++;
          if (qEdge[r*8+c] !== 8'd0) begin bad++; $display("[TB] FAIL flat_edge r=%0d c=%0d got=%0d want=0", r, c, qEdge[r*8+c]); end
          if (r >= 2) begin
            total++;
            if (qPix[r*8+c] !== 24'h0) begin bad++; $display("[TB] FAIL flat_pixel r=%0d c=%0d got=%h want=000000", r, c, qPix[r*8+c]); end
          end
        end
    end
  endtask

  task automatic test_step_magnitude();
    mode = 2'b01; en = 1'b1; thresh = 8'd0;
    runFrame(4, 8, 1, 1'b1);
    total++;
    if (qEdge.size() !== 32) begin
      bad++; $display("[TB] FAIL step_count got=%0d want=32", qEdge.size());
    end else begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 8; c++) begin
          logic [7:0] expE;
          expE = (r >= 2 && (c - 1 == 3 || c - 1 == 4)) ? 8'd255 : 8'd0;
          total++;
          if (qEdge[r*8+c] !== expE) begin bad++; $display("[TB] FAIL step_edge r=%0d c=%0d got=%0d want=%0d", r, c, qEdge[r*8+c], expE); end
          total++;
          if (qPix[r*8+c] !== splat(expE)) begin bad++; $display("[TB] FAIL step_pixel r=%0d c=%0d got=%h want=%h", r, c, qPix[r*8+c], splat(expE)); end
        end
    end
  endtask

  task automatic test_threshold();
    logic [7:0] thrList [3];
    thrList[0] = 8'd128; thrList[1] = 8'd255; thrList[2] = 8'd0;
    mode = 2'b10; en = 1'b1;
    for (int t = 0; t < 3; t++) begin
      thresh = thrList[t];
      runFrame(4, 8, 1, 1'b1);
      total++;
      if (qPix.size() !== 32) begin
        bad++; $display("[TB] FAIL thr_count thr=%0d got=%0d want=32", thrList[t], qPix.size());
      end else begin
        for (int r = 0; r < 4; r++)
          for (int c = 0; c < 8; c++) begin
            logic [23:0] expP;
            if (thrList[t] == 8'd0) expP = 24'hFFFFFF;
            else expP = (r >= 2 && (c - 1 == 3 || c - 1 == 4)) ? 24'hFFFFFF : 24'h0;
            total++;
            if (qPix[r*8+c] !== expP) begin bad++; $display("[TB] FAIL thr_pixel thr=%0d r=%0d c=%0d got=%h want=%h", thrList[t], r, c, qPix[r*8+c], expP); end
          end
      end
    end
  endtask

  task automatic test_bypass();
    thresh = 8'd0;
    for (int pass = 0; pass < 2; pass++) begin
      // first run: mode 00 enabled; second run: mode 01 but disabled, which must also bypass
      mode = (pass == 0) ? 2'b00 : 2'b01;
      en   = (pass == 0) ? 1'b1 : 1'b0;
      runFrame(3, 8, 2, 1'b1);
      total++;
      if (qPix.size() !== 24) begin
        bad++; $display("[TB] FAIL bypass_count run=%0d got=%0d want=24", pass, qPix.size());
      end else begin
        for (int r = 1; r < 3; r++)
          for (int c = 1; c < 8; c++) begin
            total++;
            if (qPix[r*8+c] !== pixAt(2, r - 1, c - 1)) begin bad++; $display("[TB] FAIL bypass_pixel run=%0d r=%0d c=%0d got=%h want=%h", pass, r, c, qPix[r*8+c], pixAt(2, r - 1, c - 1)); end
            total++;
            if (qPass[r*8+c] !== passAt(r - 1, c - 1)) begin bad++; $display("[TB] FAIL bypass_pass run=%0d r=%0d c=%0d got=%h want=%h", pass, r, c, qPass[r*8+c], passAt(r - 1, c - 1)); end
          end
      end
    end
    en = 1'b1;
  endtask

  task automatic test_horizontal_channels();
    mode = 2'b01; en = 1'b1; thresh = 8'd0;
    runFrame(5, 8, 3, 1'b1);
    total++;
    if (qPix.size() !== 40) begin
      bad++; $display("[TB] FAIL horiz_count got=%0d want=40", qPix.size());
    end else begin
      for (int r = 0; r < 5; r++)
        for (int c = 0; c < 8; c++) begin
          logic hit;
          hit = (r == 2 || r == 3) && c >= 2;
          total++;
          if (qEdge[r*8+c] !== (hit ? 8'd255 : 8'd0)) begin bad++; $display("[TB] FAIL horiz_edge r=%0d c=%0d got=%0d want=%0d", r, c, qEdge[r*8+c], hit ? 255 : 0); end
          total++;
          if (qPix[r*8+c] !== (hit ? 24'hFF0050 : 24'h0)) begin bad++; $display("[TB] FAIL horiz_pixel r=%0d c=%0d got=%h want=%h", r, c, qPix[r*8+c], hit ? 24'hFF0050 : 24'h0); end
        end
    end
  endtask

  task automatic test_cartoon();
    mode = 2'b11; en = 1'b1; thresh = 8'd100;
    runFrame(4, 8, 1, 1'b1);
    total++;
    if (qPix.size() !== 32) begin
      bad++; $display("[TB] FAIL cartoon_count got=%0d want=32", qPix.size());
    end else begin
      for (int r = 2; r < 4; r++)
        for (int c = 1; c < 8; c++) begin
          logic [23:0] expP;
          logic onEdge;
          onEdge = (c - 1 == 3 || c - 1 == 4);
`ifdef EDGE_PIPE_CARTOON_EN
          expP = onEdge ? 24'h0 : pixAt(1, r - 1, c - 1);
`else
          expP = onEdge ? 24'hFFFFFF : 24'h0;
`endif
          total++;
          if (qPix[r*8+c] !== expP) begin bad++; $display("[TB] FAIL cartoon_pixel r=%0d c=%0d got=%h want=%h", r, c, qPix[r*8+c], expP); end
          total++;
          if (qEdge[r*8+c] !== (onEdge ? 8'd255 : 8'd0)) begin bad++; $display("[TB] FAIL cartoon_edge r=%0d c=%0d got=%0d want=%0d", r, c, qEdge[r*8+c], onEdge ? 255 : 0); end
        end
    end
  endtask

  task automatic test_reset_mid_frame();
    int lat;
    int early;
    mode = 2'b00; en = 1'b1; thresh = 8'd0; line_len = 13'd8;
    clearQueues();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 8; c++)
        if (r < 3 || c < 4) applyStimulus(r, c, 2, r == 0 && c == 0);
    total++;
    if (valid_out !== 1'b1) begin bad++; $display("[TB] FAIL mid_prereset_valid got=%0d want=1", valid_out); end
    #2;
    rst = 1'b0; valid_in = 1'b0; sof = 1'b0;
    #1;
    total++; if (valid_out !== 1'b0)  begin bad++; $display("[TB] FAIL mid_reset_valid got=%0d want=0", valid_out); end
    total++; if (pixel_out !== 24'h0) begin bad++; $display("[TB] FAIL mid_reset_pixel got=%h want=000000", pixel_out); end
    total++; if (edge_out !== 8'h0)   begin bad++; $display("[TB] FAIL mid_reset_edge got=%0d want=0", edge_out); end
    total++; if (pass_thru !== 24'h0) begin bad++; $display("[TB] FAIL mid_reset_pass got=%h want=000000", pass_thru); end
    @(negedge clk);
    rst = 1'b1;
    early = 0;
    repeat (4) begin
      @(negedge clk);
      if (valid_out) early++;
    end
    total++;
    if (early !== 0) begin bad++; $display("[TB] FAIL post_reset_idle_valid got=%0d want=0", early); end
    // first pixel after release must surface exactly four cycles later
    applyStimulus(0, 0, 1, 1'b0);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      valid_in = 1'b0;
      if (valid_out) begin
        lat = k;
        break;
      end
    end
    total++;
    if (lat !== 4) begin bad++; $display("[TB] FAIL latency got=%0d want=4 (0 means timeout)", lat); end
    idle(6);
    // restart without sof: the cleared row counter alone must hide stale line-buffer data
    mode = 2'b01;
    runFrame(4, 8, 1, 1'b0);
    total++;
    if (qEdge.size() !== 32) begin
      bad++; $display("[TB] FAIL restart_count got=%0d want=32", qEdge.size());
    end else begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 8; c++) begin
          logic [7:0] expE;
          expE = (r >= 2 && (c - 1 == 3 || c - 1 == 4)) ? 8'd255 : 8'd0;
          total++;
          if (qEdge[r*8+c] !== expE) begin bad++; $display("[TB] FAIL restart_edge r=%0d c=%0d got=%0d want=%0d", r, c, qEdge[r*8+c], expE); end
        end
    end
  endtask

  // Main sequence
  initial begin
    en = 1'b1; sof = 1'b0; valid_in = 1'b0; col = 13'd0; line_len = 13'd8;
    mode = 2'b00; thresh = 8'd0; pixel_in = 24'h0; pass_in = 24'h0;
    test_reset();
    test_flat();
    test_step_magnitude();
    test_threshold();
    test_bypass();
    test_horizontal_channels();
    test_cartoon();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety net against a hung simulation
  initial begin
    #500000;
    $display("[TB] FAIL watchdog simulation did not finish got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
